wb_multi_retire: RTL
====================

Name: wb_multi_retire

Overview:
- Parametrised successor to the single-lane writeback stage.
- Retires up to LANES instructions per cycle from the MEM latch.
- Resolves same-cycle register and CSR write collisions, and drives registered register-file and CSR write ports to DE.
- Keeps architectural statistics (retired, branch and prediction-hit counters) and halts the pipeline on a halt-type instruction.

Parameters:
- LANES, 2, retire lanes per cycle (1..4); lane 0 is oldest.
- DBITS, 32, data width.
- REGNOBITS, 5, register index width.
- CSRNOBITS, 12, CSR index width.
- CNTBITS, 32, statistic counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  LANES  lane holds a retiring instruction.
- in_wr_reg  in  LANES  lane writes a GPR.
- in_rd  in  LANES*REGNOBITS  destination GPR per lane.
- in_regval  in  LANES*DBITS  GPR write data per lane.
- in_wr_csr  in  LANES  lane writes a CSR.
- in_csrno  in  LANES*CSRNOBITS  destination CSR per lane.
- in_csrval  in  LANES*DBITS  CSR write data per lane.
- in_is_branch  in  LANES  lane is a conditional branch.
- in_br_hit  in  LANES  branch prediction was correct.
- in_halt  in  LANES  lane is a halt-type instruction.
- stats_clr  in  1  synchronous clear of the branch and hit counters.
- wb_we  out  LANES  GPR write enable per lane, to DE.
- wb_rd  out  LANES*REGNOBITS  GPR write index per lane.
- wb_val  out  LANES*DBITS  GPR write data per lane.
- csr_we  out  1  CSR write enable.
- csr_no  out  CSRNOBITS  CSR write index.
- csr_val  out  DBITS  CSR write data.
- retire_count  out  CNTBITS  instructions retired.
- branch_count  out  CNTBITS  branches retired.
- hit_count  out  CNTBITS  correctly predicted branches.
- halted  out  1  halt has retired.
- stall_fe  out  1  freeze fetch.

Behaviour:
- Reset (reset low, asynchronous): every output is 0, all counters are 0, state is RUN.
- All outputs are registered. Inputs sampled at edge N appear on the outputs after edge N.
- Effective-valid mask ev:
  - ev[i] = in_valid[i], unless a lane j<i has in_valid[j] & in_halt[j].
  - Lanes younger than a halt are squashed.
  - The halt lane itself is effective.
- GPR write enable: we[i] = ev[i] & in_wr_reg[i] & (rd[i] != 0).
  - If ev/we lanes i<j write the same rd in one cycle, we[i] is cleared; the youngest lane wins.
  - wb_rd and wb_val always pass the lane fields through. Only wb_we is masked.
- CSR port: single write port.
  - The youngest lane with ev & in_wr_csr drives csr_no and csr_val.
  - csr_we = 1 if any such lane exists. Otherwise csr_we = 0 and csr_no/csr_val hold their previous values.
- Counters:
  - retire_count += popcount(ev). Wraps modulo 2^CNTBITS.
  - branch_count += popcount(ev & in_is_branch). Saturates at all-ones.
  - hit_count += popcount(ev & in_is_branch & in_br_hit). Saturates at all-ones. in_br_hit on a non-branch lane is ignored.
  - stats_clr zeroes branch_count and hit_count. Clear wins over a same-cycle increment (result 0).
  - retire_count is unaffected by stats_clr.
- State machine: RUN, HALTED.
  - RUN -> HALTED at the edge that samples any ev & in_halt. That cycle's writes and counts are performed normally.
  - In HALTED:
    - ev is forced to 0; all inputs are ignored.
    - wb_we = 0 and csr_we = 0.
    - Counters hold, except that stats_clr still clears.
    - halted = 1 and stall_fe = 1.
  - HALTED exits only on reset.
- Reset asserted mid-operation discards any in-flight write; outputs go to 0 immediately.
- No backpressure: every valid lane in RUN retires in the cycle it is presented.

Decomposition:
- Shared package:
  - Lane field offsets/slicing helpers for the flattened buses.
  - State encoding: RUN = 1'b0, HALTED = 1'b1.
  - Counter width and default LANES constants.
- One combinational sub-module, wb_retire_mask. Inputs: valid, halt, wr_reg, rd, wr_csr. Outputs: ev, we, csr_sel.
- The top level holds the registers, counters and FSM.

Test Plan:
- Reset with random inputs -> all outputs 0. Release, then lane0 {wr_reg, rd=5, val=0x1234} -> next cycle wb_we=01, wb_rd[0]=5, wb_val[0]=0x1234, retire_count=1.
- Lane0 and lane1 both write rd=7 (0xAA, 0xBB) -> wb_we=10 and lane 1 data 0xBB. A write to rd=0 alone -> wb_we=00, retire_count still increments.
- Lane0 halt with lane1 valid writing rd=3 -> wb_we=00, retire_count +1, halted=1, stall_fe=1. Further valid inputs over 5 cycles -> no writes, counters frozen.
- Three cycles of two branches, 3 hits total -> branch_count=6, hit_count=3. Then stats_clr coinciding with 2 branches -> both 0, retire_count unchanged by the clear.
- Force branch_count to all-ones minus 1, present 2 branches -> saturates at all-ones. Force retire_count to all-ones, retire 2 -> wraps to 1.
- Lanes 0 and 1 write CSR 0x300 with 0x11 and 0x22 -> csr_we=1, csr_val=0x22. Next cycle with no CSR write -> csr_we=0, csr_no/csr_val held.

Source files
------------

// File: rtl/wb_multi_retire_pkg.sv
// Shared definitions for the multi-lane writeback stage: state encoding,
// default sizes and lane slicing for the flattened per-lane buses.
package wb_multi_retire_pkg;

  localparam int unsigned DEF_LANES   = 2;
  localparam int unsigned DEF_CNTBITS = 32;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } wb_state_e;

  // Low bit offset of a lane's field inside a flattened LANES*width bus.
  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/wb_multi_retire_if.sv
// Retire-lane inputs and writeback/statistics outputs of wb_multi_retire.
interface wb_multi_retire_if
  import wb_multi_retire_pkg::*;
#(
  parameter int unsigned LANES     = DEF_LANES,
  parameter int unsigned DBITS     = 32,
  parameter int unsigned REGNOBITS = 5,
  parameter int unsigned CSRNOBITS = 12,
  parameter int unsigned CNTBITS   = DEF_CNTBITS
);
  logic [LANES-1:0]           in_valid;
  logic [LANES-1:0]           in_wr_reg;
  logic [LANES*REGNOBITS-1:0] in_rd;
  logic [LANES*DBITS-1:0]     in_regval;
  logic [LANES-1:0]           in_wr_csr;
  logic [LANES*CSRNOBITS-1:0] in_csrno;
  logic [LANES*DBITS-1:0]     in_csrval;
  logic [LANES-1:0]           in_is_branch;
  logic [LANES-1:0]           in_br_hit;
  logic [LANES-1:0]           in_halt;
  logic                       stats_clr;

  logic [LANES-1:0]           wb_we;
  logic [LANES*REGNOBITS-1:0] wb_rd;
  logic [LANES*DBITS-1:0]     wb_val;
  logic                       csr_we;
  logic [CSRNOBITS-1:0]       csr_no;
  logic [DBITS-1:0]           csr_val;
  logic [CNTBITS-1:0]         retire_count;
  logic [CNTBITS-1:0]         branch_count;
  logic [CNTBITS-1:0]         hit_count;
  logic                       halted;
  logic                       stall_fe;

  modport master (
    output in_valid, in_wr_reg, in_rd, in_regval, in_wr_csr, in_csrno, in_csrval,
           in_is_branch, in_br_hit, in_halt, stats_clr,
    input  wb_we, wb_rd, wb_val, csr_we, csr_no, csr_val,
           retire_count, branch_count, hit_count, halted, stall_fe
  );

  modport slave (
    input  in_valid, in_wr_reg, in_rd, in_regval, in_wr_csr, in_csrno, in_csrval,
           in_is_branch, in_br_hit, in_halt, stats_clr,
    output wb_we, wb_rd, wb_val, csr_we, csr_no, csr_val,
           retire_count, branch_count, hit_count, halted, stall_fe
  );

endinterface

// File: rtl/wb_retire_mask.sv
// Per-lane retire qualification: halt squashing, GPR write-after-write
// resolution (youngest lane wins) and one-hot selection of the CSR writer.
module wb_retire_mask
  import wb_multi_retire_pkg::*;
#(
  parameter int unsigned LANES     = DEF_LANES,
  parameter int unsigned REGNOBITS = 5
) (
  input  logic [LANES-1:0]           valid,
  input  logic [LANES-1:0]           halt,
  input  logic [LANES-1:0]           wr_reg,
  input  logic [LANES*REGNOBITS-1:0] rd,
  input  logic [LANES-1:0]           wr_csr,
  output logic [LANES-1:0]           ev,
  output logic [LANES-1:0]           we,
  output logic [LANES-1:0]           csr_sel
);

  logic [LANES-1:0] we_raw;

  always_comb begin
    logic squash;
    squash  = 1'b0;
    ev      = '0;
    we_raw  = '0;
    csr_sel = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      ev[i]     = valid[i] & ~squash;
      squash    = squash | (valid[i] & halt[i]);
      we_raw[i] = ev[i] & wr_reg[i] & (rd[lane_lo(i, REGNOBITS) +: REGNOBITS] != '0);
      if (ev[i] & wr_csr[i]) begin
        csr_sel    = '0;
        csr_sel[i] = 1'b1;
      end
    end
  end

  // An older lane loses its enable if any younger enabled lane targets the same GPR.
  always_comb begin
    we = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      we[i] = we_raw[i];
      for (int unsigned j = i + 1; j < LANES; j++) begin
        if (we_raw[j] && (rd[lane_lo(j, REGNOBITS) +: REGNOBITS] ==
                          rd[lane_lo(i, REGNOBITS) +: REGNOBITS]))
          we[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_multi_retire.sv
// Multi-lane writeback stage: registered GPR/CSR write ports to DE,
// architectural statistics counters and the RUN/HALTED state machine.
module wb_multi_retire
  import wb_multi_retire_pkg::*;
#(
  parameter int unsigned LANES     = DEF_LANES,
  parameter int unsigned DBITS     = 32,
  parameter int unsigned REGNOBITS = 5,
  parameter int unsigned CSRNOBITS = 12,
  parameter int unsigned CNTBITS   = DEF_CNTBITS
) (
  input logic               clk,
  input logic               reset,
  wb_multi_retire_if.slave  bus
);

  wb_state_e           state;
  logic                run;
  logic [LANES-1:0]    ev, we, csr_sel;
  logic [CSRNOBITS-1:0] sel_no;
  logic [DBITS-1:0]    sel_val;
  logic [2:0]          n_ret, n_br, n_hit;
  logic [CNTBITS:0]    br_sum, hit_sum;
  logic [CNTBITS-1:0]  br_next, hit_next;

  assign run = (state == RUN);

  // Gating valid while halted makes every downstream enable and count zero.
  wb_retire_mask #(
    .LANES     (LANES),
    .REGNOBITS (REGNOBITS)
  ) u_mask (
    .valid   (bus.in_valid & {LANES{run}}),
    .halt    (bus.in_halt),
    .wr_reg  (bus.in_wr_reg),
    .rd      (bus.in_rd),
    .wr_csr  (bus.in_wr_csr),
    .ev      (ev),
    .we      (we),
    .csr_sel (csr_sel)
  );

  always_comb begin
    sel_no  = '0;
    sel_val = '0;
    n_ret   = '0;
    n_br    = '0;
    n_hit   = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (csr_sel[i]) begin
        sel_no  = bus.in_csrno[lane_lo(i, CSRNOBITS) +: CSRNOBITS];
        sel_val = bus.in_csrval[lane_lo(i, DBITS) +: DBITS];
      end
      n_ret = n_ret + 3'(ev[i]);
      n_br  = n_br  + 3'(ev[i] & bus.in_is_branch[i]);
      n_hit = n_hit + 3'(ev[i] & bus.in_is_branch[i] & bus.in_br_hit[i]);
    end
    br_sum   = {1'b0, bus.branch_count} + (CNTBITS+1)'(n_br);
    hit_sum  = {1'b0, bus.hit_count} + (CNTBITS+1)'(n_hit);
    br_next  = br_sum[CNTBITS]  ? '1 : br_sum[CNTBITS-1:0];
    hit_next = hit_sum[CNTBITS] ? '1 : hit_sum[CNTBITS-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= RUN;
      bus.wb_we        <= '0;
      bus.wb_rd        <= '0;
      bus.wb_val       <= '0;
      bus.csr_we       <= 1'b0;
      bus.csr_no       <= '0;
      bus.csr_val      <= '0;
      bus.retire_count <= '0;
      bus.branch_count <= '0;
      bus.hit_count    <= '0;
    end else begin
      bus.wb_we  <= we;
      bus.csr_we <= |csr_sel;
      if (run) begin
        bus.wb_rd  <= bus.in_rd;
        bus.wb_val <= bus.in_regval;
      end
      if (|csr_sel) begin
        bus.csr_no  <= sel_no;
        bus.csr_val <= sel_val;
      end
      bus.retire_count <= bus.retire_count + CNTBITS'(n_ret);
      if (bus.stats_clr) begin
        bus.branch_count <= '0;
        bus.hit_count    <= '0;
      end else begin
        bus.branch_count <= br_next;
        bus.hit_count    <= hit_next;
      end
      if (run && |(ev & bus.in_halt))
        state <= HALTED;
    end
  end

  assign bus.halted   = (state == HALTED);
  assign bus.stall_fe = (state == HALTED);

endmodule
